// File: rtl/serializer_8bit_pkg.sv
// serializer_8bit shared types and helpers.
// Optional even-parity frame bit: SERIALIZER_PARITY_EN.
package serializer_8bit_pkg;

  localparam int SER_W = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] start_sel(
    input logic msb_first
  );
    return msb_first ? 3'd7 : 3'd0;
  endfunction

  function automatic logic [SEL_W-1:0] last_sel(
    input logic msb_first
  );
    return msb_first ? 3'd0 : 3'd7;
  endfunction

  function automatic logic [SEL_W-1:0] next_sel(
    input logic             msb_first,
    input logic [SEL_W-1:0] s
  );
    return msb_first ? s - 3'd1 : s + 3'd1;
  endfunction

endpackage

// File: rtl/serializer_8bit_if.sv
// Byte-in / bit-out bundle of serializer_8bit.
// master drives bytes, slave is the serializer.
interface serializer_8bit_if;
  import serializer_8bit_pkg::*;

  logic [SER_W-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid,
    input  sel, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid,
    output sel, busy, done
  );

endinterface

// File: rtl/serializer_8bit_mux.sv
// Combinational 8:1 bit-select mux.
// out_o = in_i[sel_i].
module serializer_8bit_mux
  import serializer_8bit_pkg::*;
(
  input  logic [SER_W-1:0] in_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             out_o
);

  assign out_o = in_i[sel_i];

endmodule

// File: rtl/serializer_8bit.sv
// 8-bit parallel-in, serial-out converter.
// `define SERIALIZER_PARITY_EN adds an even-parity bit.
module serializer_8bit
  import serializer_8bit_pkg::*;
#(
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  serializer_8bit_if.slave   bus
);

  localparam logic [SEL_W-1:0] START =
    start_sel(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST =
    last_sel(MSB_FIRST);

  state_t           state_q;
  logic [SER_W-1:0] hold_q;
  logic [SEL_W-1:0] sel_q;

  logic in_shift;
  logic in_par;
  logic is_last;
  logic ready;
  logic accept;
  logic sout_raw;
  logic sout_d;

  assign in_shift = (state_q == ST_SHIFT);
  assign in_par   = (state_q == ST_PARITY);
  assign is_last  = in_shift && (sel_q == LAST);

`ifdef SERIALIZER_PARITY_EN
  assign ready = (state_q == ST_IDLE) | in_par;
  assign bus.done = in_par;
`else
  assign ready = (state_q == ST_IDLE) | is_last;
  assign bus.done = is_last;
`endif

  assign accept = bus.din_valid & ready;

  serializer_8bit_mux u_mux (
    .in_i  (hold_q),
    .sel_i (sel_q),
    .out_o (sout_raw)
  );

  always_comb begin
    sout_d = IDLE_LEVEL;
    unique case (1'b1)
      in_shift: sout_d = sout_raw;
      in_par:   sout_d = ^hold_q;
      default:  sout_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      sel_q   <= START;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            hold_q  <= bus.din;
            sel_q   <= START;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sel_q != LAST) begin
            sel_q <= next_sel(MSB_FIRST, sel_q);
          end else begin
            sel_q <= START;
`ifdef SERIALIZER_PARITY_EN
            state_q <= ST_PARITY;
`else
            // Back-to-back byte keeps the stream gapless
            if (accept) begin
              hold_q  <= bus.din;
              state_q <= ST_SHIFT;
            end else begin
              state_q <= ST_IDLE;
            end
`endif
          end
        end
        ST_PARITY: begin
          sel_q <= START;
          if (accept) begin
            hold_q  <= bus.din;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= START;
        end
      endcase
    end
  end

  assign bus.din_ready  = ready;
  assign bus.sout       = sout_d;
  assign bus.sout_valid = in_shift | in_par;
  assign bus.busy       = in_shift | in_par;
  assign bus.sel        = sel_q;

endmodule

// File: tb/tb_serializer_8bit.sv
// Scoreboard bench for serializer_8bit (LSB- and MSB-first).
// Honors SERIALIZER_PARITY_EN when defined.
module tb_serializer_8bit;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 9 : 8;

  typedef struct {
    logic       b;
    logic       d;
    logic [2:0] s;
    logic       cs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;

  int checks = 0;
  int errors = 0;

  exp_t q [2][$];

  serializer_8bit_if b0 ();
  serializer_8bit_if b1 ();

  assign b0.din       = din;
  assign b0.din_valid = din_valid;
  assign b1.din       = din;
  assign b1.din_valid = din_valid;

  serializer_8bit #(
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  serializer_8bit #(
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int w,
                     input logic [7:0] a,
                     input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h",
               n, w, a, e);
    end
  endtask

  task automatic push_exp(input logic [7:0] b);
    logic [2:0] idx;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        idx = (w == 1) ? 3'(7 - i) : 3'(i);
        q[w].push_back('{b[idx], (i == 7) && !PAR,
                         idx, 1'b1});
      end
      if (PAR)
        q[w].push_back('{^b, 1'b1, 3'd0, 1'b0});
    end
  endtask

  task automatic mon(input int w, input logic v,
                     input logic s, input logic d,
                     input logic [2:0] sl,
                     input logic bz);
    exp_t e;
    if (v) begin
      if (q[w].size() == 0) begin
        chk("unexpected_bit", w, 8'(v), 8'd0);
      end else begin
        e = q[w].pop_front();
        chk("sout", w, 8'(s), 8'(e.b));
        chk("done", w, 8'(d), 8'(e.d));
        if (e.cs) chk("sel", w, 8'(sl), 8'(e.s));
      end
    end else begin
      chk("idle_sout", w, 8'(s), 8'd0);
      chk("idle_done", w, 8'(d), 8'd0);
    end
    chk("busy", w, 8'(bz), 8'(v));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, b0.sout_valid, b0.sout, b0.done,
          b0.sel, b0.busy);
      mon(1, b1.sout_valid, b1.sout, b1.done,
          b1.sel, b1.busy);
    end
  end

  task automatic accept(input logic [7:0] b);
    int n = 0;
    din       = b;
    din_valid = 1'b1;
    @(negedge clk);
    while (!b0.din_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!b0.din_ready) begin
      chk("accept_timeout", 0, 8'(b0.din_ready), 8'd1);
    end else begin
      @(posedge clk);
      #1;
      push_exp(b);
    end
    din_valid = 1'b0;
  endtask

  task automatic chk_rst_out();
    chk("rst_valid", 0, 8'(b0.sout_valid), 8'd0);
    chk("rst_busy",  0, 8'(b0.busy),       8'd0);
    chk("rst_ready", 0, 8'(b0.din_ready),  8'd1);
    chk("rst_done",  0, 8'(b0.done),       8'd0);
    chk("rst_sout",  0, 8'(b0.sout),       8'd0);
    chk("rst_sel",   0, 8'(b0.sel),        8'd0);
    chk("rst_valid", 1, 8'(b1.sout_valid), 8'd0);
    chk("rst_ready", 1, 8'(b1.din_ready),  8'd1);
    chk("rst_sel",   1, 8'(b1.sel),        8'd7);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    #1;
    chk_rst_out();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    accept(8'hA5);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("c9_valid", 0, 8'(b0.sout_valid), 8'(PAR));
    chk("c9_ready", 0, 8'(b0.din_ready),  8'd1);
    @(posedge clk);
    #1;

    accept(8'h81);
    repeat (12) @(posedge clk);
    #1;

    accept(8'hFF);
    fork
      accept(8'h00);
      begin
        for (int k = 1; k <= 2 * NB; k++) begin
          @(negedge clk);
          chk("b2b_valid", 0, 8'(b0.sout_valid), 8'd1);
          chk("b2b_ready", 0, 8'(b0.din_ready),
              8'(k % NB == 0));
        end
      end
    join
    repeat (12) @(posedge clk);
    #1;

    accept(8'h5A);
    @(posedge clk);
    #1;
    din       = 8'h33;
    din_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 din_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    accept(8'hC3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_rst_out();
    q[0].delete();
    q[1].delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    accept(8'h3C);
    repeat (12) @(posedge clk);
    #1;

    accept(8'h07);
    repeat (12) @(posedge clk);
    #1;

    chk("drain", 0, 8'(q[0].size()), 8'd0);
    chk("drain", 1, 8'(q[1].size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
